esc_quad_pwm: RTL and testbench
===============================

Name: esc_quad_pwm

Overview:
- Consumes the four 11-bit unsigned motor speeds from the flight controller and generates four ESC PWM pulse trains: front, back, left and right.
- Speeds are captured into shadow registers on a write strobe, scaled to pulse widths in a pipeline register, and applied atomically at frame boundaries.
- Sits between the flight controller and the ESC output pins; one block drives all four motors.

Parameters:
- PERIOD_W, 20, width of the free-running frame counter. Frame = 2^PERIOD_W clocks (about 21 ms at 50 MHz).
- OFFSET, 6250, minimum pulse width in clocks, i.e. the zero-speed pulse.
- SCALE, 3, clocks of pulse width per speed LSB.
- Constraint: OFFSET + 2047*SCALE < 2^PERIOD_W. This is checked by an elaboration assertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrt  in  1  capture strobe; samples all four speeds this cycle
- frnt_spd  in  11  unsigned front motor speed
- bck_spd  in  11  unsigned back motor speed
- lft_spd  in  11  unsigned left motor speed
- rght_spd  in  11  unsigned right motor speed
- frnt  out  1  front ESC PWM, registered
- bck  out  1  back ESC PWM, registered
- lft  out  1  left ESC PWM, registered
- rght  out  1  right ESC PWM, registered

Behaviour:
- Reset: asynchronous on rst_n low. Clears cnt=0, all shadow speeds=0, all width_nxt=OFFSET, all width_act=OFFSET, all PWM outputs=0.
- Reset mid-pulse forces the outputs low immediately, without waiting for a clock.
- Counter: cnt (PERIOD_W bits) increments every clock and wraps from MAX=2^PERIOD_W-1 to 0. There are no stall conditions.
- Capture: at an edge with wrt=1, shadow_x <= x_spd for all four channels. wrt=0 holds the shadows.
- Width pipeline:
  - width_nxt_x <= OFFSET + SCALE*shadow_x every clock.
  - This is one cycle behind the shadow, so two cycles from wrt to width_nxt.
  - Arithmetic is unsigned. 14 bits suffice for the defaults (max 12391); the general width is clog2(OFFSET+2047*SCALE+1).
  - SCALE=3 is built as (s<<1)+s, with no multiplier.
- Frame latch: at the edge where cnt==MAX, width_act_x <= width_nxt_x for all four channels simultaneously. width_act is constant for the whole frame.
- Late capture: a wrt arriving 0 or 1 cycles before the cnt==MAX edge is not reflected in the upcoming frame. It appears in the following frame.
- PWM per channel:
  - Set at the edge where cnt==MAX.
  - Cleared at the edge where cnt+1==width_act_x.
  - Result: the output is high exactly for cycles with cnt in [0, width_act_x-1], i.e. width_act_x clocks.
- Simultaneous set and clear cannot occur, because width_act >= OFFSET >= 2.
- First frame after reset: cnt starts at 0 with the output low, so no pulse is emitted until the first wrap.
- Outputs come straight from flops, so they are glitch-free.
- Channels are independent apart from the shared cnt and the shared frame latch.

Optional Feature:
- ESC_FRAME_STB_EN: adds output port frm_stb (1 bit, registered, reset 0).
  - It pulses high for one cycle, in the cycle where cnt==0, i.e. coincident with the first high cycle of each frame's pulses.
  - Intended to let the controller time its wrt strobe.
- Without the macro, the port and its flop do not exist and behaviour is otherwise identical.

Decomposition:
- Package esc_pkg holds:
  - SPD_W=11
  - default OFFSET and SCALE
  - the width-calculation function (OFFSET + SCALE*spd)
  - the typedef spd_t (logic [10:0])
- Sub-module esc_chan: one channel containing shadow, width_nxt, width_act and the pwm flop.
  - Inputs: clk, rst_n, wrt, spd, frame_edge (cnt==MAX), cnt.
  - It is instantiated four times.
- The top level owns cnt, frame_edge and the optional frm_stb.

Test Plan (PERIOD_W=15 in simulation, so the frame is 32768 clocks):
1. Reset, then no wrt: the first frame shows all outputs low. Every later frame has a 6250-clock pulse on all four outputs.
2. wrt with frnt=0, bck=2047, lft=1000, rght=1 mid-frame: the next frame has pulse widths 6250, 12391, 9250 and 6253 clocks, each rising at cnt==0.
3. wrt with all speeds 500 in the cycle where cnt==MAX-1: the upcoming frame still uses the old widths. The frame after that uses 7750.
4. rst_n dropped at cnt==100 during a pulse: all outputs go low immediately without a clock edge. After release, cnt restarts and the first frame is silent.
5. Multiple wrt strobes within one frame (speeds 100, then 200): only the last value applies, giving 6850 in the next frame. Widths never change mid-frame.
6. With ESC_FRAME_STB_EN defined: frm_stb is high for exactly one cycle per frame, aligned with the rising edges of the PWM outputs.

Source files
------------

// File: rtl/esc_pkg.sv
// esc_quad_pwm shared types, defaults and the speed-to-width mapping.
// Optional frame strobe is enabled by defining ESC_FRAME_STB_EN.
package esc_pkg;

  localparam int SPD_W = 11;
  localparam int MAX_SPD = (1 << SPD_W) - 1;
  localparam int OFFSET_DEF = 6250;
  localparam int SCALE_DEF = 3;

  typedef logic [SPD_W-1:0] spd_t;

  // Pulse width in clocks for a given speed.
  function automatic int calc_width(
    input spd_t spd,
    input int   offset,
    input int   scale
  );
    logic [31:0] s;
    s = 32'(spd);
    if (scale == 3)
      return offset + int'((s << 1) + s);
    else
      return offset + int'(s * 32'(scale));
  endfunction

  function automatic int width_bits(
    input int offset,
    input int scale
  );
    return $clog2(offset + MAX_SPD * scale + 1);
  endfunction

endpackage

// File: rtl/esc_chan.sv
// One ESC channel: shadow speed, width pipeline, frame latch and PWM flop.
// Shared by all four motors of esc_quad_pwm.
module esc_chan
  import esc_pkg::*;
#(
  parameter int PERIOD_W = 20,
  parameter int OFFSET   = OFFSET_DEF,
  parameter int SCALE    = SCALE_DEF,
  parameter int WID_W    = width_bits(OFFSET_DEF, SCALE_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrt,
  input  spd_t                spd,
  input  logic                frame_edge,
  input  logic [PERIOD_W-1:0] cnt,
  output logic                pwm
);

  localparam logic [WID_W-1:0] OFF_W = WID_W'(OFFSET);

  spd_t                shadow;
  logic [WID_W-1:0]    width_nxt;
  logic [WID_W-1:0]    width_act;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic                clr;

  assign cnt_nxt = cnt + 1'b1;
  assign clr     = (cnt_nxt == PERIOD_W'(width_act));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      width_nxt <= OFF_W;
      width_act <= OFF_W;
      pwm       <= 1'b0;
    end else begin
      if (wrt)
        shadow <= spd;
      width_nxt <=
        WID_W'(calc_width(shadow, OFFSET, SCALE));
      // New widths only take effect on the frame boundary.
      if (frame_edge)
        width_act <= width_nxt;
      if (frame_edge)
        pwm <= 1'b1;
      else if (clr)
        pwm <= 1'b0;
    end
  end

endmodule

// File: rtl/esc_quad_pwm.sv
// Four-channel ESC PWM generator with frame-synchronous width update.
// Define ESC_FRAME_STB_EN to add the frm_stb frame-start output.
module esc_quad_pwm
  import esc_pkg::*;
#(
  parameter int PERIOD_W = 20,
  parameter int OFFSET   = OFFSET_DEF,
  parameter int SCALE    = SCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wrt,
  input  spd_t frnt_spd,
  input  spd_t bck_spd,
  input  spd_t lft_spd,
  input  spd_t rght_spd,
  output logic frnt,
  output logic bck,
  output logic lft,
  output logic rght
`ifdef ESC_FRAME_STB_EN
  ,
  output logic frm_stb
`endif
);

  localparam int WID_W = width_bits(OFFSET, SCALE);

  if (OFFSET + MAX_SPD * SCALE >= (1 << PERIOD_W))
  begin : g_bad_cfg
    $error("esc_quad_pwm: widest pulse exceeds frame");
  end

  logic [PERIOD_W-1:0] cnt;
  logic                frame_edge;
  spd_t                spd [4];
  logic [3:0]          pwm;

  assign frame_edge = &cnt;

  assign spd[0] = frnt_spd;
  assign spd[1] = bck_spd;
  assign spd[2] = lft_spd;
  assign spd[3] = rght_spd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    esc_chan #(
      .PERIOD_W (PERIOD_W),
      .OFFSET   (OFFSET),
      .SCALE    (SCALE),
      .WID_W    (WID_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt        (wrt),
      .spd        (spd[i]),
      .frame_edge (frame_edge),
      .cnt        (cnt),
      .pwm        (pwm[i])
    );
  end

  assign frnt = pwm[0];
  assign bck  = pwm[1];
  assign lft  = pwm[2];
  assign rght = pwm[3];

`ifdef ESC_FRAME_STB_EN
  // Registered, so it lines up with the cnt==0 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frm_stb <= 1'b0;
    else
      frm_stb <= frame_edge;
  end
`endif

endmodule

// File: tb/tb_esc_quad_pwm.sv
// Self-checking bench for esc_quad_pwm against a frame-level model.
// Uses a short frame and reduced offset to keep the run compact.
module tb_esc_quad_pwm;

  localparam int PW  = 13;
  localparam int F   = 1 << PW;
  localparam int MAX = F - 1;
  localparam int OFF = 1000;
  localparam int SC  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [10:0] fs = '0, bs = '0, ls = '0, rs = '0;
  logic        frnt, bck, lft, rght;
`ifdef ESC_FRAME_STB_EN
  logic        frm_stb;
`endif

  esc_quad_pwm #(
    .PERIOD_W (PW),
    .OFFSET   (OFF),
    .SCALE    (SC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt      (wrt),
    .frnt_spd (fs),
    .bck_spd  (bs),
    .lft_spd  (ls),
    .rght_spd (rs),
    .frnt     (frnt),
    .bck      (bck),
    .lft      (lft),
    .rght     (rght)
`ifdef ESC_FRAME_STB_EN
    ,
    .frm_stb  (frm_stb)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input int a, input int e);
    vecs++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, a, e, $time);
    end
  endtask

  // Model: a capture takes effect in the frame latched at least
  // two edges after it; pulse high while cnt < width.
  typedef struct {
    int e;
    int v [4];
  } cap_t;

  cap_t caps [$];
  int   m_cnt = 0;
  int   edge_n = 0;
  bit   started = 0;
  int   act [4] = '{OFF, OFF, OFF, OFF};
  int   sel [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      edge_n = 0;
      started = 0;
      caps.delete();
      for (int i = 0; i < 4; i++) act[i] = OFF;
    end else begin
      edge_n++;
      if (wrt)
        caps.push_back('{edge_n,
          '{int'(fs), int'(bs), int'(ls), int'(rs)}});
      if (m_cnt == MAX) begin
        sel = '{0, 0, 0, 0};
        foreach (caps[k])
          if (caps[k].e <= edge_n - 2) sel = caps[k].v;
        for (int i = 0; i < 4; i++) act[i] = OFF + SC * sel[i];
        started = 1;
      end
      m_cnt = (m_cnt + 1) % F;
    end
  end

  int hi [4] = '{0, 0, 0, 0};
  int last_w [4] = '{0, 0, 0, 0};
  logic [3:0] q;
  logic       e;

  always @(negedge clk) begin
    q = {rght, lft, bck, frnt};
    for (int i = 0; i < 4; i++) begin
      e = started && (m_cnt < act[i]);
      chk($sformatf("pwm%0d", i), int'(q[i]), int'(e));
      if (!rst_n) hi[i] = 0;
      else hi[i] += int'(q[i]);
    end
`ifdef ESC_FRAME_STB_EN
    chk("frm_stb", int'(frm_stb),
        int'(started && m_cnt == 0));
`endif
    if (rst_n && m_cnt == MAX) begin
      last_w = hi;
      hi = '{0, 0, 0, 0};
    end
  end

  task automatic wait_cnt(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != c && n < 3 * F);
    if (m_cnt != c) chk("wait_timeout", m_cnt, c);
  endtask

  task automatic strobe(input int f, b, l, r);
    fs = 11'(f); bs = 11'(b); ls = 11'(l); rs = 11'(r);
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic chk_w(input string nm, input int w0, w1, w2, w3);
    chk({nm, "_frnt"}, last_w[0], w0);
    chk({nm, "_bck"},  last_w[1], w1);
    chk({nm, "_lft"},  last_w[2], w2);
    chk({nm, "_rght"}, last_w[3], w3);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", int'({frnt, bck, lft, rght}), 0);
    rst_n = 1'b1;

    wait_cnt(MAX);
    wait_cnt(5);
    chk_w("frame0", 0, 0, 0, 0);

    wait_cnt(4000);
    strobe(0, 2047, 1000, 1);
    wait_cnt(5);
    chk_w("frame1", OFF, OFF, OFF, OFF);
    chk("pin_act0", act[0], 1000);
    chk("pin_act1", act[1], 7141);
    chk("pin_act2", act[2], 4000);
    chk("pin_act3", act[3], 1003);

    wait_cnt(MAX - 1);
    strobe(500, 500, 500, 500);
    wait_cnt(5);
    chk_w("frame2", 1000, 7141, 4000, 1003);
    chk("pin_late", act[1], 7141);

    wait_cnt(5);
    chk_w("frame3", 1000, 7141, 4000, 1003);
    chk("pin_act500", act[2], 2500);
    wait_cnt(200);
    strobe(100, 100, 100, 100);
    wait_cnt(300);
    strobe(200, 200, 200, 200);
    wait_cnt(5);
    chk_w("frame4", 2500, 2500, 2500, 2500);
    chk("pin_act200", act[0], 1600);

    wait_cnt(100);
    chk("pre_rst_high", int'({frnt, bck, lft, rght}), 15);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_frnt", int'(frnt), 0);
    chk("async_rst_bck",  int'(bck),  0);
    chk("async_rst_lft",  int'(lft),  0);
    chk("async_rst_rght", int'(rght), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(MAX);
    wait_cnt(5);
    chk_w("silent", 0, 0, 0, 0);

    for (int c = 0; c < 2 * F; c++) begin
      fs = 11'($urandom);
      bs = 11'($urandom);
      ls = 11'($urandom);
      rs = 11'($urandom);
      wrt = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    wrt = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
